// File: rtl/damq_shared_buffer.sv
`default_nettype none
// ============================================================================
// Module   : damq_shared_buffer
// Brief    : DAMQ router input buffer. One shared flit memory is split at run
//            time into per-VC linked-list FIFOs fed from a free-address FIFO.
// Revision : 1.0  initial release
// ============================================================================
module damq_shared_buffer #(
    parameter int NUM_VCS      = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 16,
    parameter int MIN_RESERVED = 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            write_enable,
    input  logic [((NUM_VCS > 1) ? $clog2(NUM_VCS) : 1)-1:0] write_vc,
    input  logic [DATA_WIDTH-1:0]                           flit_in,
    input  logic                                            read_enable,
    input  logic [((NUM_VCS > 1) ? $clog2(NUM_VCS) : 1)-1:0] read_vc,
    output logic [DATA_WIDTH-1:0]                           flit_out,
    output logic                                            flit_out_valid,
    output logic [NUM_VCS-1:0]                              vc_empty,
    output logic [NUM_VCS-1:0]                              vc_write_ok,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]               free_count,
    output logic                                            protocol_error
);

    localparam int c_vc_w   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int c_addr_w = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(BUFFER_DEPTH + 1);
    localparam int c_pad_n  = 1 << c_vc_w;
    localparam logic [c_cnt_w-1:0]  c_min_res = c_cnt_w'(MIN_RESERVED);
    localparam logic [c_addr_w-1:0] c_last    = c_addr_w'(BUFFER_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem       [BUFFER_DEPTH];
    logic [c_addr_w-1:0]   r_next_ptr  [BUFFER_DEPTH];
    logic [c_addr_w-1:0]   r_free_fifo [BUFFER_DEPTH];
    logic [c_addr_w-1:0]   r_head      [NUM_VCS];
    logic [c_addr_w-1:0]   r_tail      [NUM_VCS];
    logic [c_cnt_w-1:0]    r_count     [NUM_VCS];
    logic [c_addr_w-1:0]   r_free_rd;
    logic [c_addr_w-1:0]   r_free_wr;
    logic [c_cnt_w-1:0]    r_free_count;
    logic [DATA_WIDTH-1:0] r_flit_out;
    logic                  r_flit_out_valid;
    logic                  r_protocol_error;

    logic [c_cnt_w-1:0]    w_deficit;
    logic [NUM_VCS-1:0]    w_vc_empty;
    logic [NUM_VCS-1:0]    w_vc_write_ok;
    logic [c_pad_n-1:0]    w_ok_pad;
    logic [c_pad_n-1:0]    w_nonempty_pad;
    logic                  w_wr_legal;
    logic                  w_rd_legal;
    logic                  w_wr_to_empty;
    logic [c_addr_w-1:0]   w_alloc;

    function automatic logic [c_addr_w-1:0] f_wrap_inc(input logic [c_addr_w-1:0] p);
        return (p == c_last) ? '0 : p + c_addr_w'(1);
    endfunction

    // Acceptance looks only at registered state: a slot freed by a read in
    // this same cycle only becomes allocatable on the next one.
    always_comb begin
        w_deficit      = '0;
        w_vc_empty     = '0;
        w_vc_write_ok  = '0;
        w_ok_pad       = '0;
        w_nonempty_pad = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (r_count[v] < c_min_res)
                w_deficit = w_deficit + (c_min_res - r_count[v]);
        end
        for (int v = 0; v < NUM_VCS; v++) begin
            w_vc_empty[v]    = (r_count[v] == '0);
            w_vc_write_ok[v] = (r_count[v] < c_min_res) ? (r_free_count != '0)
                                                        : (r_free_count > w_deficit);
        end
        // Padding to the full index range makes out-of-range VCs read as illegal.
        w_ok_pad[NUM_VCS-1:0]       = w_vc_write_ok;
        w_nonempty_pad[NUM_VCS-1:0] = ~w_vc_empty;
    end

    assign w_wr_legal    = write_enable && w_ok_pad[write_vc];
    assign w_rd_legal    = read_enable && w_nonempty_pad[read_vc];
    assign w_alloc       = r_free_fifo[r_free_rd];
    assign w_wr_to_empty = (r_count[write_vc] == '0) ||
                           (w_rd_legal && (read_vc == write_vc) &&
                            (r_count[write_vc] == c_cnt_w'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_head[v]  <= '0;
                r_tail[v]  <= '0;
                r_count[v] <= '0;
            end
            for (int i = 0; i < BUFFER_DEPTH; i++)
                r_free_fifo[i] <= c_addr_w'(i);
            r_free_rd        <= '0;
            r_free_wr        <= '0;
            r_free_count     <= c_cnt_w'(BUFFER_DEPTH);
            r_flit_out       <= '0;
            r_flit_out_valid <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            r_flit_out_valid <= w_rd_legal;
            if (w_rd_legal) begin
                r_flit_out               <= r_mem[r_head[read_vc]];
                r_head[read_vc]          <= r_next_ptr[r_head[read_vc]];
                r_free_fifo[r_free_wr]   <= r_head[read_vc];
                r_free_wr                <= f_wrap_inc(r_free_wr);
            end
            // Placed after the read so a write into a just-emptied VC wins the head.
            if (w_wr_legal) begin
                r_tail[write_vc] <= w_alloc;
                if (w_wr_to_empty)
                    r_head[write_vc] <= w_alloc;
                r_free_rd <= f_wrap_inc(r_free_rd);
            end
            for (int v = 0; v < NUM_VCS; v++) begin
                case ({w_wr_legal && (write_vc == c_vc_w'(v)),
                       w_rd_legal && (read_vc == c_vc_w'(v))})
                    2'b10:   r_count[v] <= r_count[v] + c_cnt_w'(1);
                    2'b01:   r_count[v] <= r_count[v] - c_cnt_w'(1);
                    default: r_count[v] <= r_count[v];
                endcase
            end
            case ({w_wr_legal, w_rd_legal})
                2'b10:   r_free_count <= r_free_count - c_cnt_w'(1);
                2'b01:   r_free_count <= r_free_count + c_cnt_w'(1);
                default: r_free_count <= r_free_count;
            endcase
            if ((write_enable && !w_wr_legal) || (read_enable && !w_rd_legal))
                r_protocol_error <= 1'b1;
        end
    end

    // Storage and link fields carry no reset; they are only read via live pointers.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_legal) begin
            r_mem[w_alloc] <= flit_in;
            if (!w_wr_to_empty)
                r_next_ptr[r_tail[write_vc]] <= w_alloc;
        end
    end

    assign flit_out       = r_flit_out;
    assign flit_out_valid = r_flit_out_valid;
    assign vc_empty       = w_vc_empty;
    assign vc_write_ok    = w_vc_write_ok;
    assign free_count     = r_free_count;
    assign protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_damq_shared_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_damq_shared_buffer
// Brief    : Self-checking bench for damq_shared_buffer against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_damq_shared_buffer;

    localparam int NV    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int MR    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_enable;
    logic [1:0]    write_vc;
    logic [DW-1:0] flit_in;
    logic          read_enable;
    logic [1:0]    read_vc;
    logic [DW-1:0] flit_out;
    logic          flit_out_valid;
    logic [NV-1:0] vc_empty;
    logic [NV-1:0] vc_write_ok;
    logic [4:0]    free_count;
    logic          protocol_error;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NV][$];
    bit            m_valid;
    bit            m_err;
    logic [DW-1:0] m_flit;

    damq_shared_buffer #(
        .NUM_VCS(NV), .DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .MIN_RESERVED(MR)
    ) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_vc(write_vc), .flit_in(flit_in),
        .read_enable(read_enable), .read_vc(read_vc),
        .flit_out(flit_out), .flit_out_valid(flit_out_valid),
        .vc_empty(vc_empty), .vc_write_ok(vc_write_ok),
        .free_count(free_count), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    function automatic int m_free();
        int t = 0;
        for (int v = 0; v < NV; v++) t += mq[v].size();
        return DEPTH - t;
    endfunction

    function automatic bit m_ok(input int vc);
        int def = 0;
        for (int v = 0; v < NV; v++)
            if (mq[v].size() < MR) def += MR - mq[v].size();
        if (mq[vc].size() < MR) return m_free() > 0;
        return (m_free() - def) > 0;
    endfunction

    function automatic logic [NV-1:0] m_ok_vec();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_ok(v);
        return r;
    endfunction

    function automatic logic [NV-1:0] m_empty_vec();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = (mq[v].size() == 0);
        return r;
    endfunction

    // Drives one clock of stimulus and advances the reference model.
    task automatic cycle(input bit we, input int wvc, input logic [DW-1:0] d,
                         input bit re, input int rvc);
        bit wl, rl;
        wl = we && (wvc < NV) && m_ok(wvc);
        rl = re && (rvc < NV) && (mq[rvc].size() > 0);
        write_enable = we; write_vc = wvc[1:0]; flit_in = d;
        read_enable  = re; read_vc  = rvc[1:0];
        @(posedge clk); #1;
        write_enable = 1'b0; read_enable = 1'b0;
        m_valid = rl;
        if (rl) m_flit = mq[rvc].pop_front();
        if (wl) mq[wvc].push_back(d);
        if ((we && !wl) || (re && !rl)) m_err = 1'b1;
    endtask

    task automatic do_reset(input bit re, input int rvc);
        reset = 1'b1; write_enable = 1'b0; read_enable = re; read_vc = rvc[1:0];
        @(posedge clk); #1;
        reset = 1'b0; read_enable = 1'b0;
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_valid = 1'b0; m_err = 1'b0; m_flit = '0;
    endtask

    task automatic test_reset();
        do_reset(0, 0);
        cycle(0, 0, '0, 0, 0);
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL reset_free got=%0d exp=16", free_count); end
        checks++; if (vc_empty !== 4'b1111) begin errors++; $display("FAIL reset_empty got=%b exp=1111", vc_empty); end
        checks++; if (vc_write_ok !== 4'b1111) begin errors++; $display("FAIL reset_ok got=%b exp=1111", vc_write_ok); end
        checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", flit_out_valid); end
        checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", protocol_error); end
        checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit got=%h exp=0", flit_out); end
    endtask

    task automatic test_fifo_order();
        logic [DW-1:0] exp_v [3];
        exp_v[0] = 64'h11; exp_v[1] = 64'h22; exp_v[2] = 64'h33;
        for (int i = 0; i < 3; i++) cycle(1, 2, exp_v[i], 0, 0);
        checks++; if (vc_empty !== 4'b1011) begin errors++; $display("FAIL fifo_empty got=%b exp=1011", vc_empty); end
        checks++; if (free_count !== 5'd13) begin errors++; $display("FAIL fifo_free got=%0d exp=13", free_count); end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, 1, 2);
            checks++; if (flit_out_valid !== 1'b1 || flit_out !== exp_v[i])
                begin errors++; $display("FAIL fifo_read%0d got=%h/%b exp=%h/1", i, flit_out, flit_out_valid, exp_v[i]); end
        end
        cycle(0, 0, '0, 0, 0);
        checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL fifo_valid_drop got=%b exp=0", flit_out_valid); end
        checks++; if (vc_empty !== 4'b1111 || free_count !== 5'd16)
            begin errors++; $display("FAIL fifo_drained got=%b/%0d exp=1111/16", vc_empty, free_count); end
    endtask

    task automatic test_reservation();
        do_reset(0, 0);
        for (int i = 0; i < 13; i++) cycle(1, 0, 64'(100 + i), 0, 0);
        checks++; if (vc_write_ok !== 4'b1110) begin errors++; $display("FAIL resv_ok got=%b exp=1110", vc_write_ok); end
        checks++; if (free_count !== 5'd3) begin errors++; $display("FAIL resv_free got=%0d exp=3", free_count); end
        checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL resv_err_pre got=%b exp=0", protocol_error); end
        cycle(1, 0, 64'hDEAD, 0, 0);
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL resv_err got=%b exp=1", protocol_error); end
        checks++; if (free_count !== 5'd3) begin errors++; $display("FAIL resv_drop got=%0d exp=3", free_count); end
        for (int v = 1; v < 4; v++) begin
            cycle(1, v, 64'(200 + v), 0, 0);
            checks++; if (free_count !== 5'(3 - v))
                begin errors++; $display("FAIL resv_vc%0d_free got=%0d exp=%0d", v, free_count, 3 - v); end
        end
        checks++; if (vc_write_ok !== 4'b0000) begin errors++; $display("FAIL resv_full_ok got=%b exp=0000", vc_write_ok); end
        cycle(0, 0, '0, 1, 0);
        checks++; if (flit_out !== 64'd100 || flit_out_valid !== 1'b1)
            begin errors++; $display("FAIL resv_head got=%h/%b exp=64/1", flit_out, flit_out_valid); end
    endtask

    task automatic test_same_vc_rw();
        do_reset(0, 0);
        cycle(1, 1, 64'hAA, 0, 0);
        cycle(1, 1, 64'hBB, 1, 1);
        checks++; if (flit_out !== 64'hAA || flit_out_valid !== 1'b1)
            begin errors++; $display("FAIL samevc_old got=%h/%b exp=aa/1", flit_out, flit_out_valid); end
        checks++; if (vc_empty[1] !== 1'b0 || free_count !== 5'd15)
            begin errors++; $display("FAIL samevc_count got=%b/%0d exp=0/15", vc_empty[1], free_count); end
        cycle(0, 0, '0, 1, 1);
        checks++; if (flit_out !== 64'hBB || flit_out_valid !== 1'b1)
            begin errors++; $display("FAIL samevc_new got=%h/%b exp=bb/1", flit_out, flit_out_valid); end
        checks++; if (vc_empty !== 4'b1111 || protocol_error !== 1'b0)
            begin errors++; $display("FAIL samevc_end got=%b/%b exp=1111/0", vc_empty, protocol_error); end
    endtask

    task automatic test_interleave();
        int            wv [4];
        int            rv [4];
        logic [DW-1:0] wd [4];
        logic [DW-1:0] ed [4];
        wv = '{0, 1, 0, 1}; rv = '{1, 0, 1, 0};
        wd = '{64'hA, 64'hB, 64'hC, 64'hD}; ed = '{64'hB, 64'hA, 64'hD, 64'hC};
        do_reset(0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, wv[i], wd[i], 0, 0);
            checks++; if (free_count !== 5'(m_free()))
                begin errors++; $display("FAIL ilv_wfree%0d got=%0d exp=%0d", i, free_count, m_free()); end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, '0, 1, rv[i]);
            checks++; if (flit_out !== ed[i] || flit_out_valid !== 1'b1)
                begin errors++; $display("FAIL ilv_read%0d got=%h exp=%h", i, flit_out, ed[i]); end
            checks++; if (free_count !== 5'(m_free()))
                begin errors++; $display("FAIL ilv_rfree%0d got=%0d exp=%0d", i, free_count, m_free()); end
        end
    endtask

    task automatic test_random();
        bit we, re;
        int wvc, rvc;
        do_reset(0, 0);
        for (int n = 0; n < 500; n++) begin
            wvc = $urandom_range(NV - 1);
            rvc = $urandom_range(NV - 1);
            we  = ($urandom_range(3) != 0);
            re  = ($urandom_range(2) != 0);
            if (we && !m_ok(wvc) && $urandom_range(15) != 0) we = 1'b0;
            if (re && mq[rvc].size() == 0 && $urandom_range(15) != 0) re = 1'b0;
            cycle(we, wvc, {$urandom, $urandom}, re, rvc);
            checks++; if (flit_out_valid !== m_valid || flit_out !== m_flit)
                begin errors++; $display("FAIL rnd_out@%0d got=%h/%b exp=%h/%b", n, flit_out, flit_out_valid, m_flit, m_valid); end
            checks++; if (free_count !== 5'(m_free()) || vc_empty !== m_empty_vec())
                begin errors++; $display("FAIL rnd_occ@%0d got=%0d/%b exp=%0d/%b", n, free_count, vc_empty, m_free(), m_empty_vec()); end
            checks++; if (vc_write_ok !== m_ok_vec() || protocol_error !== m_err)
                begin errors++; $display("FAIL rnd_ok@%0d got=%b/%b exp=%b/%b", n, vc_write_ok, protocol_error, m_ok_vec(), m_err); end
        end
    endtask

    task automatic test_reset_midtraffic();
        do_reset(0, 0);
        cycle(0, 0, '0, 1, 3);
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL mid_err_set got=%b exp=1", protocol_error); end
        for (int i = 0; i < 8; i++) cycle(1, i % NV, 64'(300 + i), 0, 0);
        checks++; if (free_count !== 5'd8) begin errors++; $display("FAIL mid_fill got=%0d exp=8", free_count); end
        do_reset(1, 0);
        checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", flit_out_valid); end
        checks++; if (free_count !== 5'd16 || vc_empty !== 4'b1111)
            begin errors++; $display("FAIL mid_state got=%0d/%b exp=16/1111", free_count, vc_empty); end
        checks++; if (protocol_error !== 1'b0 || vc_write_ok !== 4'b1111)
            begin errors++; $display("FAIL mid_flags got=%b/%b exp=0/1111", protocol_error, vc_write_ok); end
    endtask

    initial begin
        reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0;
        write_vc = '0; read_vc = '0; flit_in = '0;
        m_valid = 1'b0; m_err = 1'b0; m_flit = '0;
        test_reset();
        test_fifo_order();
        test_reservation();
        test_same_vc_rw();
        test_interleave();
        test_random();
        test_reset_midtraffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/damq_shared_buffer.md
Name: damq_shared_buffer

Overview:
- Dynamically allocated multi-queue (DAMQ) input buffer for one router input port.
- One shared flit memory is partitioned at run time into per-VC linked-list FIFOs, with a hardware free-address list.
- Generalises the single-bank shared buffer with these additions:
  - parametrised VC count, width and depth;
  - per-VC occupancy counters;
  - a per-VC guaranteed minimum reservation, so one VC cannot starve the others;
  - a registered read-data valid;
  - a sticky protocol-error flag.
- Sits between the input link and the VC/switch allocators; vc_write_ok feeds upstream credit logic.

Parameters:
- num_vcs, 4, number of virtual channels sharing the memory.
- data_width, 64, flit width in bits.
- buffer_depth, 16, total flit slots; must be at least num_vcs*min_reserved.
- min_reserved, 1, slots guaranteed to each VC (0 = fully shared).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- write_enable  input  1  push flit_in into VC write_vc this cycle.
- write_vc  input  clogb(num_vcs)  target VC of the write.
- flit_in  input  data_width  write data.
- read_enable  input  1  pop the head flit of VC read_vc.
- read_vc  input  clogb(num_vcs)  source VC of the read.
- flit_out  output  data_width  registered read data.
- flit_out_valid  output  1  flit_out holds data popped in the previous cycle.
- vc_empty  output  num_vcs  bit v = VC v holds no flits.
- vc_write_ok  output  num_vcs  bit v = a write to VC v this cycle is legal.
- free_count  output  clogb(buffer_depth+1)  unallocated slots.
- protocol_error  output  1  sticky; set by an illegal write or read.

Behaviour:
- State:
  - memory[buffer_depth];
  - next_ptr[buffer_depth];
  - per-VC head, tail and count (count width clogb(buffer_depth+1));
  - free-address FIFO (circular, depth buffer_depth, own rd/wr pointers plus free_count).
- Reset (synchronous):
  - All counts are 0, all head/tail pointers are 0.
  - Free FIFO entry i holds address i; free_count = buffer_depth.
  - flit_out = 0, flit_out_valid = 0, protocol_error = 0.
  - vc_empty = all ones, vc_write_ok = all ones (when buffer_depth > 0).
  - Reset asserted mid-traffic discards all queued flits; no flit_out_valid is asserted in the cycle after reset.
- Write acceptance (combinational, from registered state only):
  - deficit = sum over v of max(0, min_reserved - count[v]).
  - shared_free = free_count - deficit.
  - vc_write_ok[v] = (count[v] < min_reserved) ? (free_count > 0) : (shared_free > 0).
  - A slot freed by a same-cycle read is NOT usable by the write in that cycle.
- Legal write: addr = head of the free FIFO (popped). memory[addr] <= flit_in; tail[vc] <= addr; count[vc]++.
  - If count[vc] was 0, or is effectively 0 after a same-cycle read of that VC: head[vc] <= addr.
  - Otherwise: next_ptr[tail[vc]] <= addr.
- Legal read (count[read_vc] > 0):
  - flit_out <= memory[head[read_vc]]; flit_out_valid <= 1 in the next cycle (latency 1).
  - head[read_vc] <= next_ptr[head[read_vc]]; count--; the old head address is pushed to the free FIFO.
- No read, or an illegal read: flit_out holds its value; flit_out_valid <= 0.
- Simultaneous read and write:
  - Different VCs: both complete independently. The free FIFO pushes and pops in the same cycle, so free_count is unchanged.
  - Same VC with count 1: the read returns the old flit. The new flit becomes the sole entry (head = tail = new addr), and count stays 1.
  - Same VC with count > 1: normal append plus pop; count is unchanged.
- Illegal write (write_enable while vc_write_ok[write_vc] = 0): the flit is dropped, no state changes, protocol_error <= 1.
- Illegal read (read_enable while vc_empty[read_vc] = 1): ignored, protocol_error <= 1.
- protocol_error clears only on reset.
- An out-of-range VC index (>= num_vcs) is treated as illegal.
- Per-VC order is strict FIFO. Ordering across VCs is unconstrained.
- Invariant: sum of count[v] + free_count = buffer_depth at all times.

Test Plan:
1. Reset, then idle (defaults: 4 VCs, depth 16, min_reserved 1) -> free_count=16, vc_empty=4'b1111, vc_write_ok=4'b1111, flit_out_valid=0, protocol_error=0.
2. Write 0x11, 0x22, 0x33 to VC2, then read VC2 three times -> flit_out = 0x11, 0x22, 0x33 on consecutive cycles, each valid one cycle after its read; vc_empty[2] returns to 1; free_count returns to 16.
3. Write 13 flits to VC0 -> vc_write_ok[0]=0 while vc_write_ok[3:1]=3'b111 and free_count=3. A 14th write to VC0 is dropped and protocol_error=1. Writes to VC1, VC2 and VC3 still succeed (free_count reaches 0).
4. VC1 holds 0xAA only; same cycle read VC1 + write 0xBB to VC1 -> next cycle flit_out=0xAA with valid, count[1] stays 1; a following read returns 0xBB.
5. Interleave writes VC0:A, VC1:B, VC0:C, VC1:D, then read VC1, VC0, VC1, VC0 -> outputs B, A, D, C; invariant holds every cycle.
6. Reset asserted with 8 flits queued across VCs plus a read in flight -> next cycle flit_out_valid=0, free_count=16, all vc_empty=1, protocol_error=0.
